// File: rtl/fpcvt_int_wbq_pkg.sv
// Shared definitions for the FP->int convert writeback queue.
// Holds the extension-mode encoding and the helper that selects it.
package fpcvt_int_wbq_pkg;

    localparam int RES_W = 64;

    // How a convert result is widened to the 64-bit integer register.
    typedef enum logic [1:0] {
        EXT_NONE = 2'd0,   // 64-bit destination, result passes through
        EXT_ZERO = 2'd1,   // 32-bit destination, zero-extend bit 31
        EXT_SIGN = 2'd2    // 32-bit destination, sign-extend bit 31
    } ext_mode_e;

    // Map the destination-size and sign-extend flags onto an extension mode.
    function automatic ext_mode_e ext_mode(input logic is32, input logic sx);
        if (!is32) begin
            return EXT_NONE;
        end else if (sx) begin
            return EXT_SIGN;
        end else begin
            return EXT_ZERO;
        end
    endfunction

endpackage

// File: rtl/fpcvt_ext.sv
// Extension mux: widens a 32-bit convert result to 64 bits (sign or zero)
// or passes a 64-bit result through unchanged.
module fpcvt_ext
    import fpcvt_int_wbq_pkg::*;
(
    input  logic [RES_W-1:0] res,
    input  ext_mode_e        mode,
    output logic [RES_W-1:0] res_ext
);

    // Select the widened result for the requested destination size.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        res_ext = res;
        unique case (mode)
            EXT_SIGN: res_ext = {{32{res[31]}}, res[31:0]};
            EXT_ZERO: res_ext = {32'b0, res[31:0]};
            default:  res_ext = res;
        endcase
    end

endmodule

// File: rtl/fpcvt_int_wbq.sv
// In-order writeback queue behind the FP lane-2 FP->int convert unit.
// Captures each convert result with its alt flag and destination tag,
// drains it to the integer writeback port under valid/ready, and raises
// a registered stall early enough that converts already in the pipe
// still fit.
module fpcvt_int_wbq
    import fpcvt_int_wbq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 9,
    parameter int SLACK = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_en,
    input  logic [RES_W-1:0]         in_res,
    input  logic                     in_alt,
    input  logic [TAG_W-1:0]         in_tag,
    input  logic                     in_is32,
    input  logic                     in_sx,
    input  logic                     flush,
    input  logic                     wb_rdy,
    output logic                     wb_en,
    output logic [RES_W-1:0]         wb_data,
    output logic [TAG_W-1:0]         wb_tag,
    output logic                     wb_alt,
    output logic                     stall,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    // Stall threshold; never below 1 so an empty queue never stalls issue.
    localparam int STALL_AT = (DEPTH > SLACK) ? (DEPTH - SLACK) : 1;

    typedef struct packed {
        logic [RES_W-1:0] data;
        logic [TAG_W-1:0] tag;
        logic             alt;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW-1:0]    wr_nxt, rd_nxt, cnt_nxt;
    logic [RES_W-1:0] res_ext;
    logic             empty, full, push, pop, drop;

    // Widening happens on the way in, so the head entry is already final.
    fpcvt_ext u_ext (
        .res     (in_res),
        .mode    (ext_mode(in_is32, in_sx)),
        .res_ext (res_ext)
    );

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count = wr_ptr - rd_ptr;

    // Head presentation; gated by wb_en so an empty queue shows all zeros.
    assign head    = mem[rd_ptr[AW-1:0]];
    assign wb_en   = ~empty;
    assign wb_data = wb_en ? head.data : '0;
    assign wb_tag  = wb_en ? head.tag  : '0;
    assign wb_alt  = wb_en ? head.alt  : 1'b0;

    // A full queue still accepts when the head leaves on the same edge.
    assign pop  = wb_en & wb_rdy;
    assign push = in_en & (~full | pop) & ~flush;
    assign drop = in_en & full & ~pop & ~flush;

    // Next-state pointers; flush collapses the queue onto the write pointer.
    always_comb begin
        wr_nxt  = wr_ptr + PW'(push);
        rd_nxt  = flush ? wr_ptr : rd_ptr + PW'(pop);
        cnt_nxt = wr_nxt - rd_nxt;
    end

    // Pointer, stall and sticky overflow state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            stall  <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            stall  <= (cnt_nxt >= PW'(STALL_AT));
            ovf    <= ovf | drop;
        end
    end

    // Entry storage, written at the tail on each accepted push.
    // NOTE: the array has no reset; the pointers define which entries are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= '{data: res_ext, tag: in_tag, alt: in_alt};
        end
    end

endmodule

// File: tb/tb_fpcvt_int_wbq.sv
// Directed bench for fpcvt_int_wbq. Stimulus pushes hand-computed expected
// entries into a scoreboard queue; a monitor pops and compares on every
// writeback handshake. Direct checks cover occupancy, stall, ovf, flush
// and asynchronous reset.
module tb_fpcvt_int_wbq;

    localparam int DEPTH = 4;
    localparam int TAG_W = 9;

    typedef struct packed {
        logic [63:0]      data;
        logic [TAG_W-1:0] tag;
        logic             alt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_en;
    logic [63:0]      in_res;
    logic             in_alt;
    logic [TAG_W-1:0] in_tag;
    logic             in_is32;
    logic             in_sx;
    logic             flush;
    logic             wb_rdy;
    logic             wb_en;
    logic [63:0]      wb_data;
    logic [TAG_W-1:0] wb_tag;
    logic             wb_alt;
    logic             stall;
    logic [2:0]       count;
    logic             ovf;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    fpcvt_int_wbq #(.DEPTH(DEPTH), .TAG_W(TAG_W), .SLACK(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_en   (in_en),
        .in_res  (in_res),
        .in_alt  (in_alt),
        .in_tag  (in_tag),
        .in_is32 (in_is32),
        .in_sx   (in_sx),
        .flush   (flush),
        .wb_rdy  (wb_rdy),
        .wb_en   (wb_en),
        .wb_data (wb_data),
        .wb_tag  (wb_tag),
        .wb_alt  (wb_alt),
        .stall   (stall),
        .count   (count),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Advance one edge and settle 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a convert result; when accept is set, queue its expected writeback.
    task automatic push(input logic [TAG_W-1:0] tag, input logic [63:0] res,
                        input logic is32, input logic sx, input logic alt,
                        input logic [63:0] exp_data, input bit accept);
        in_en   = 1'b1;
        in_tag  = tag;
        in_res  = res;
        in_is32 = is32;
        in_sx   = sx;
        in_alt  = alt;
        if (accept) q.push_back('{data: exp_data, tag: tag, alt: alt});
    endtask

    task automatic idle();
        in_en = 1'b0;
    endtask

    // Scoreboard monitor: every handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst && !flush && wb_en && wb_rdy) begin
            if (q.size() == 0) begin
                check("sb_underflow", 64'(q.size()), 64'd1);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sb_data", wb_data, e.data);
                check("sb_tag", 64'(wb_tag), 64'(e.tag));
                check("sb_alt", 64'(wb_alt), 64'(e.alt));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; in_en = 1'b0; in_res = '0; in_alt = 1'b0; in_tag = '0;
        in_is32 = 1'b0; in_sx = 1'b0; flush = 1'b0; wb_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wb_en", 64'(wb_en), 64'd0);
        check("rst_wb_data", wb_data, 64'd0);
        check("rst_wb_tag", 64'(wb_tag), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        rst = 1'b1;
        step();

        // 1: sign-extended 32-bit result, latency 1, then empty again.
        wb_rdy = 1'b1;
        push(9'd5, 64'h8000_0000_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        step(); idle();
        check("t1_wb_en", 64'(wb_en), 64'd1);
        check("t1_wb_data", wb_data, 64'hFFFF_FFFF_FFFF_FFFF);
        check("t1_wb_tag", 64'(wb_tag), 64'd5);
        step();
        check("t1_wb_en_after", 64'(wb_en), 64'd0);

        // 2: fill with writeback blocked, stall from count 2, overflow drop.
        wb_rdy = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            push(TAG_W'(i), 64'h100 + 64'(i), 1'b0, 1'b0, 1'b0, 64'h100 + 64'(i), 1'b1);
            step(); idle();
            check("t2_count", 64'(count), 64'(i));
            check("t2_stall", 64'(stall), (i >= 2) ? 64'd1 : 64'd0);
        end
        check("t2_head_held", 64'(wb_tag), 64'd1);
        push(9'd5, 64'h105, 1'b0, 1'b0, 1'b0, 64'h105, 1'b0);
        step(); idle();
        check("t2_ovf", 64'(ovf), 64'd1);
        check("t2_count_full", 64'(count), 64'd4);
        check("t2_head_still", 64'(wb_tag), 64'd1);

        // 3: push and pop on the same edge while full, then drain across the wrap.
        wb_rdy = 1'b1;
        push(9'd9, 64'h909, 1'b0, 1'b0, 1'b0, 64'h909, 1'b1);
        step(); idle();
        check("t3_count", 64'(count), 64'd4);
        for (int i = 0; i < 10; i++) begin
            if (!wb_en) break;
            step();
        end
        check("t3_drained", 64'(wb_en), 64'd0);
        check("t3_count0", 64'(count), 64'd0);
        check("t3_stall0", 64'(stall), 64'd0);
        check("t3_ovf_sticky", 64'(ovf), 64'd1);
        check("t3_sb_empty", 64'(q.size()), 64'd0);

        // 4: flush with a same-cycle push discards everything.
        wb_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(TAG_W'(9'h21 + i), 64'h2100 + 64'(i), 1'b0, 1'b0, 1'b0, 64'h2100 + 64'(i), 1'b1);
            step();
        end
        idle();
        check("t4_count3", 64'(count), 64'd3);
        check("t4_stall1", 64'(stall), 64'd1);
        flush = 1'b1;
        push(9'd7, 64'h777, 1'b0, 1'b0, 1'b0, 64'h777, 1'b0);
        q.delete();
        step(); idle(); flush = 1'b0;
        check("t4_count0", 64'(count), 64'd0);
        check("t4_wb_en0", 64'(wb_en), 64'd0);
        check("t4_stall0", 64'(stall), 64'd0);
        check("t4_ovf_kept", 64'(ovf), 64'd1);
        step();
        check("t4_still_empty", 64'(wb_en), 64'd0);

        // 5: alt flag, zero-extend, positive sign-extend; back-to-back through one entry.
        wb_rdy = 1'b1;
        push(9'h31, 64'h1234, 1'b0, 1'b1, 1'b1, 64'h1234, 1'b1);
        step();
        check("t5_alt", 64'(wb_alt), 64'd1);
        check("t5_data", wb_data, 64'h1234);
        push(9'h32, 64'hDEAD_BEEF_8765_4321, 1'b1, 1'b0, 1'b0, 64'h0000_0000_8765_4321, 1'b1);
        step();
        check("t5_wb_en_kept", 64'(wb_en), 64'd1);
        check("t5_new_head", 64'(wb_tag), 64'h32);
        push(9'h33, 64'hFFFF_FFFF_1234_5678, 1'b1, 1'b1, 1'b0, 64'h0000_0000_1234_5678, 1'b1);
        step(); idle();
        check("t5_last_head", 64'(wb_tag), 64'h33);
        step();
        check("t5_empty", 64'(wb_en), 64'd0);

        // 6: asynchronous reset with three entries queued.
        wb_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(TAG_W'(9'h41 + i), 64'h4100 + 64'(i), 1'b0, 1'b0, 1'b1, 64'h4100 + 64'(i), 1'b1);
            step();
        end
        idle();
        check("t6_count3", 64'(count), 64'd3);
        check("t6_wb_en1", 64'(wb_en), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("t6_wb_en", 64'(wb_en), 64'd0);
        check("t6_wb_data", wb_data, 64'd0);
        check("t6_wb_tag", 64'(wb_tag), 64'd0);
        check("t6_wb_alt", 64'(wb_alt), 64'd0);
        check("t6_count", 64'(count), 64'd0);
        check("t6_stall", 64'(stall), 64'd0);
        check("t6_ovf", 64'(ovf), 64'd0);
        q.delete();
        step();
        rst = 1'b1;
        step();

        // Queue works normally after reset.
        wb_rdy = 1'b1;
        push(9'h55, 64'h55, 1'b0, 1'b0, 1'b0, 64'h55, 1'b1);
        step(); idle();
        check("t6_post_tag", 64'(wb_tag), 64'h55);
        step();
        check("t6_post_empty", 64'(wb_en), 64'd0);
        check("final_sb_empty", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
